// File: rtl/csr_exc_ctrl_pkg.sv
// Package: csr_exc_ctrl_pkg
// Purpose: Shared constants, the FSM state type and the masked-write helper
//          for the exception/ERTN commit controller and its CSR file.
// Contents:
//   CSR_*        14-bit CSR addresses
//   WRMASK_*     software-writable bit masks per CSR
//   *_LSB/_MSB   field positions inside CRMD/PRMD/ESTAT
//   state_t      controller sequencing states
//   masked_write old/wdata/wmask/wrmask merge used by csrwr and csrxchg
package csr_exc_ctrl_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00c;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;

    localparam logic [31:0] WRMASK_CRMD   = 32'h0000_01ff;
    localparam logic [31:0] WRMASK_PRMD   = 32'h0000_0007;
    localparam logic [31:0] WRMASK_ESTAT  = 32'h0000_0003;
    localparam logic [31:0] WRMASK_ERA    = 32'hffff_ffff;
    localparam logic [31:0] WRMASK_EENTRY = 32'hffff_ffc0;
    localparam logic [31:0] WRMASK_SAVE   = 32'hffff_ffff;

    // CRMD.PLV/IE and PRMD.PPLV/PIE share the same low three bits,
    // so privilege save/restore is a straight copy of [2:0].
    localparam int PRIV_MSB        = 2;
    localparam int ECODE_LSB       = 16;
    localparam int ECODE_MSB       = 21;
    localparam int ESUBCODE_LSB    = 22;
    localparam int ESUBCODE_MSB    = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    function automatic logic [31:0] masked_write(
        input logic [31:0] old_val,
        input logic [31:0] wdata,
        input logic [31:0] wmask,
        input logic [31:0] wrmask
    );
        logic [31:0] eff;
        eff = wmask & wrmask;
        return (old_val & ~eff) | (wdata & eff);
    endfunction

endpackage

// File: rtl/csr_exc_ctrl_if.sv
// Interface: csr_exc_ctrl_if
// Purpose: Bundles the WB exception/ertn report, the committed CSR port and
//          the flush/redirect handshake between the pipeline and csr_exc_ctrl.
// Modports:
//   master  pipeline side: drives wb_*, csr_num/we/wmask/wdata, redirect_ready
//   slave   controller side: drives csr_rdata, flush, redirect_*, busy
interface csr_exc_ctrl_if;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        wb_ertn;
    logic [13:0] csr_num;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    modport master (
        output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_ertn,
        output csr_num, csr_we, csr_wmask, csr_wdata, redirect_ready,
        input  csr_rdata, flush, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_ertn,
        input  csr_num, csr_we, csr_wmask, csr_wdata, redirect_ready,
        output csr_rdata, flush, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/csr_exc_ctrl_regfile.sv
// Module: csr_regfile
// Purpose: Holds CRMD/PRMD/ESTAT/ERA/EENTRY/SAVE0-3, applies hardware
//          exception/ertn updates and masked software writes, and provides
//          the combinational read mux.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   csr_num         read/write address
//   csr_rdata       combinational read data (0 for unmapped CSRs)
//   sw_we           qualified software write strobe
//   csr_wmask/wdata software write mask and data
//   ex_commit       take an exception this edge (ex_ecode/ex_esubcode/ex_pc)
//   ertn_commit     take an ertn this edge
//   eentry, era     current values, used by the controller for the target
module csr_regfile
    import csr_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EENTRY_RST = 32'h0000_0000,
    parameter logic [31:0] CRMD_RST   = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rdata,
    input  logic        sw_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wdata,
    input  logic        ex_commit,
    input  logic [5:0]  ex_ecode,
    input  logic [8:0]  ex_esubcode,
    input  logic [31:0] ex_pc,
    input  logic        ertn_commit,
    output logic [31:0] eentry,
    output logic [31:0] era
);

    logic [31:0] crmd_q, prmd_q, estat_q, era_q, eentry_q;
    logic [31:0] save_q [4];

    // Bits outside each CSR's writable/HW fields are never loaded with
    // anything but 0, so storing full words keeps them reading 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_q   <= CRMD_RST & WRMASK_CRMD;
            prmd_q   <= '0;
            estat_q  <= '0;
            era_q    <= '0;
            eentry_q <= EENTRY_RST & WRMASK_EENTRY;
            for (int i = 0; i < 4; i++) save_q[i] <= '0;
        end else if (ex_commit) begin
            era_q                              <= ex_pc;
            estat_q[ECODE_MSB:ECODE_LSB]       <= ex_ecode;
            estat_q[ESUBCODE_MSB:ESUBCODE_LSB] <= ex_esubcode;
            prmd_q[PRIV_MSB:0]                 <= crmd_q[PRIV_MSB:0];
            crmd_q[PRIV_MSB:0]                 <= '0;
        end else if (ertn_commit) begin
            crmd_q[PRIV_MSB:0] <= prmd_q[PRIV_MSB:0];
        end else if (sw_we) begin
            unique case (csr_num)
                CSR_CRMD:   crmd_q   <= masked_write(crmd_q,   csr_wdata, csr_wmask, WRMASK_CRMD);
                CSR_PRMD:   prmd_q   <= masked_write(prmd_q,   csr_wdata, csr_wmask, WRMASK_PRMD);
                CSR_ESTAT:  estat_q  <= masked_write(estat_q,  csr_wdata, csr_wmask, WRMASK_ESTAT);
                CSR_ERA:    era_q    <= masked_write(era_q,    csr_wdata, csr_wmask, WRMASK_ERA);
                CSR_EENTRY: eentry_q <= masked_write(eentry_q, csr_wdata, csr_wmask, WRMASK_EENTRY);
                CSR_SAVE0:  save_q[0] <= masked_write(save_q[0], csr_wdata, csr_wmask, WRMASK_SAVE);
                CSR_SAVE1:  save_q[1] <= masked_write(save_q[1], csr_wdata, csr_wmask, WRMASK_SAVE);
                CSR_SAVE2:  save_q[2] <= masked_write(save_q[2], csr_wdata, csr_wmask, WRMASK_SAVE);
                CSR_SAVE3:  save_q[3] <= masked_write(save_q[3], csr_wdata, csr_wmask, WRMASK_SAVE);
                default: ;
            endcase
        end
    end

    always_comb begin
        csr_rdata = '0;
        unique case (csr_num)
            CSR_CRMD:   csr_rdata = crmd_q;
            CSR_PRMD:   csr_rdata = prmd_q;
            CSR_ESTAT:  csr_rdata = estat_q;
            CSR_ERA:    csr_rdata = era_q;
            CSR_EENTRY: csr_rdata = eentry_q;
            CSR_SAVE0:  csr_rdata = save_q[0];
            CSR_SAVE1:  csr_rdata = save_q[1];
            CSR_SAVE2:  csr_rdata = save_q[2];
            CSR_SAVE3:  csr_rdata = save_q[3];
            default:    csr_rdata = '0;
        endcase
    end

    assign eentry = eentry_q;
    assign era    = era_q;

endmodule

// File: rtl/csr_exc_ctrl.sv
// Module: csr_exc_ctrl
// Purpose: Exception/ERTN commit controller beside the WB stage. Accepts an
//          exception or ertn while idle, updates the CSRs, then sequences a
//          one-cycle flush followed by a valid/ready fetch redirect.
// Ports:
//   clk     clock
//   reset   synchronous, active-high
//   bus     csr_exc_ctrl_if.slave: WB report, CSR port, flush/redirect, busy
// Parameters:
//   EENTRY_RST  EENTRY reset value (bits [5:0] forced 0)
//   CRMD_RST    CRMD reset value
module csr_exc_ctrl
    import csr_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EENTRY_RST = 32'h0000_0000,
    parameter logic [31:0] CRMD_RST   = 32'h0000_0008
) (
    input logic           clk,
    input logic           reset,
    csr_exc_ctrl_if.slave bus
);

    state_t      state, state_next;
    logic [31:0] target;
    logic [31:0] eentry, era;
    logic        idle, ex_take, ertn_take, sw_we;

    // Only an idle controller listens to WB; exception beats ertn, and
    // either one swallows a CSR write committing in the same cycle.
    assign idle      = (state == ST_IDLE);
    assign ex_take   = idle && bus.wb_ex;
    assign ertn_take = idle && !bus.wb_ex && bus.wb_ertn;
    assign sw_we     = idle && bus.csr_we && !bus.wb_ex && !bus.wb_ertn;

    csr_regfile #(
        .EENTRY_RST (EENTRY_RST),
        .CRMD_RST   (CRMD_RST)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .csr_num     (bus.csr_num),
        .csr_rdata   (bus.csr_rdata),
        .sw_we       (sw_we),
        .csr_wmask   (bus.csr_wmask),
        .csr_wdata   (bus.csr_wdata),
        .ex_commit   (ex_take),
        .ex_ecode    (bus.wb_ecode),
        .ex_esubcode (bus.wb_esubcode),
        .ex_pc       (bus.wb_pc),
        .ertn_commit (ertn_take),
        .eentry      (eentry),
        .era         (era)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // The target is captured from pre-edge register values, so an EENTRY
    // write racing the exception cannot change where we jump.
    always_ff @(posedge clk) begin
        if (reset)          target <= '0;
        else if (ex_take)   target <= eentry;
        else if (ertn_take) target <= era;
    end

    always_comb begin
        state_next         = state;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.busy           = !idle;
        unique case (state)
            ST_IDLE: begin
                if (ex_take || ertn_take) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                bus.flush  = 1'b1;
                state_next = ST_REDIR;
            end
            ST_REDIR: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = target;
                if (bus.redirect_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Testbench: tb_csr_exc_ctrl
// Purpose: Scoreboard bench for csr_exc_ctrl. The stimulus side drives one
//          cycle at a time, predicts the observable outputs from a CSR-level
//          reference model and queues them; a negedge monitor pops and compares.
module tb_csr_exc_ctrl;

    localparam logic [31:0] TB_EENTRY_RST = 32'h1c00_007f;
    localparam logic [31:0] TB_CRMD_RST   = 32'h0000_0008;

    typedef struct {
        logic [13:0] num;
        logic [31:0] rdata;
        logic        busy;
        logic        flush;
        logic        rv;
        logic [31:0] rpc;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csr_exc_ctrl_if bus ();

    csr_exc_ctrl #(
        .EENTRY_RST (TB_EENTRY_RST),
        .CRMD_RST   (TB_CRMD_RST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    obs_t        obs_q[$];
    logic [31:0] redir_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    bit          mon_en       = 1'b0;

    // Reference model: architectural CSR values plus where we are in the
    // post-commit timeline (0 idle, 1 flush cycle, 2 waiting for fetch).
    logic [31:0] m_crmd, m_prmd, m_estat, m_era, m_eentry, m_target;
    logic [31:0] m_save [4];
    int          m_phase;

    function automatic logic [31:0] wr_mask_of(input logic [13:0] n);
        case (n)
            14'h000: return 32'h0000_01ff;
            14'h001: return 32'h0000_0007;
            14'h005: return 32'h0000_0003;
            14'h006: return 32'hffff_ffff;
            14'h00c: return 32'hffff_ffc0;
            14'h030, 14'h031, 14'h032, 14'h033: return 32'hffff_ffff;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [13:0] n);
        case (n)
            14'h000: return m_crmd;
            14'h001: return m_prmd;
            14'h005: return m_estat;
            14'h006: return m_era;
            14'h00c: return m_eentry;
            14'h030, 14'h031, 14'h032, 14'h033: return m_save[n - 14'h030];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_crmd   = 32'h8;
        m_prmd   = 0;
        m_estat  = 0;
        m_era    = 0;
        m_eentry = TB_EENTRY_RST & 32'hffff_ffc0;
        m_target = 0;
        for (int i = 0; i < 4; i++) m_save[i] = 0;
        m_phase  = 0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, queue the predicted outputs for this
    // cycle, then advance the model across the edge.
    task automatic applyStimulus(
        input logic        rst,
        input logic        ex,
        input logic [5:0]  ecode,
        input logic [8:0]  esub,
        input logic [31:0] pc,
        input logic        ertn,
        input logic [13:0] num,
        input logic        we,
        input logic [31:0] wmask,
        input logic [31:0] wdata,
        input logic        ready
    );
        obs_t        e;
        logic [31:0] wm, nv;
        reset              = rst;
        bus.wb_ex          = ex;
        bus.wb_ecode       = ecode;
        bus.wb_esubcode    = esub;
        bus.wb_pc          = pc;
        bus.wb_ertn        = ertn;
        bus.csr_num        = num;
        bus.csr_we         = we;
        bus.csr_wmask      = wmask;
        bus.csr_wdata      = wdata;
        bus.redirect_ready = ready;

        e.num   = num;
        e.rdata = model_read(num);
        e.busy  = (m_phase != 0);
        e.flush = (m_phase == 1);
        e.rv    = (m_phase == 2);
        e.rpc   = m_target;
        obs_q.push_back(e);
        if (m_phase == 2 && ready) redir_q.push_back(m_target);

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (ex) begin
                m_target = m_eentry;
                m_era    = pc;
                m_estat  = {1'b0, esub, ecode, 14'b0, m_estat[1:0]};
                m_prmd   = {29'b0, m_crmd[2:0]};
                m_crmd   = m_crmd & ~32'h7;
                m_phase  = 1;
            end else if (ertn) begin
                m_target = m_era;
                m_crmd   = (m_crmd & ~32'h7) | m_prmd[2:0];
                m_phase  = 1;
            end else if (we) begin
                wm = wmask & wr_mask_of(num);
                nv = (model_read(num) & ~wm) | (wdata & wm);
                case (num)
                    14'h000: m_crmd   = nv;
                    14'h001: m_prmd   = nv;
                    14'h005: m_estat  = nv;
                    14'h006: m_era    = nv;
                    14'h00c: m_eentry = nv;
                    14'h030, 14'h031, 14'h032, 14'h033: m_save[num - 14'h030] = nv;
                    default: ;
                endcase
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (ready) begin
            m_phase = 0;
        end
        #1;
    endtask

    task automatic readCycle(input logic [13:0] num, input logic ready);
        applyStimulus(0, 0, 0, 0, 0, 0, num, 0, 0, 0, ready);
    endtask

    task automatic writeCycle(input logic [13:0] num, input logic [31:0] wmask, input logic [31:0] wdata);
        applyStimulus(0, 0, 0, 0, 0, 0, num, 1, wmask, wdata, 1);
    endtask

    // Monitor: one queued prediction per cycle, plus one expected target per
    // accepted redirect handshake.
    always @(negedge clk) begin
        obs_t e;
        if (mon_en && obs_q.size() > 0) begin
            e = obs_q.pop_front();
            checkOutput($sformatf("rdata[%h]", e.num), bus.csr_rdata, e.rdata);
            checkOutput("busy", 32'(bus.busy), 32'(e.busy));
            checkOutput("flush", 32'(bus.flush), 32'(e.flush));
            checkOutput("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
            if (e.rv) checkOutput("redirect_pc", bus.redirect_pc, e.rpc);
            if (bus.redirect_valid && bus.redirect_ready) begin
                if (redir_q.size() == 0) checkOutput("unexpected handshake", 32'(1), 32'(0));
                else checkOutput("handshake pc", bus.redirect_pc, redir_q.pop_front());
            end
        end
    end

    initial begin
        logic [13:0] nums [11];
        logic [13:0] n;
        nums = '{14'h000, 14'h001, 14'h005, 14'h006, 14'h00c,
                 14'h030, 14'h031, 14'h032, 14'h033, 14'h007, 14'h3fff};

        reset = 1'b1;
        bus.wb_ex = 0; bus.wb_ecode = 0; bus.wb_esubcode = 0; bus.wb_pc = 0;
        bus.wb_ertn = 0; bus.csr_num = 0; bus.csr_we = 0; bus.csr_wmask = 0;
        bus.csr_wdata = 0; bus.redirect_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        mon_en = 1'b1;

        $display("[TB] reset state");
        for (int i = 0; i < 11; i++) readCycle(nums[i], 0);

        $display("[TB] exception entry with held redirect");
        writeCycle(14'h00c, 32'hffff_ffff, 32'h1c00_8000);
        writeCycle(14'h000, 32'h0000_0007, 32'h0000_0007);
        applyStimulus(0, 1, 6'hb, 9'h0, 32'h1c00_0100, 0, 14'h006, 0, 0, 0, 0);
        readCycle(14'h006, 0);
        readCycle(14'h005, 0);
        readCycle(14'h001, 0);
        readCycle(14'h000, 0);
        readCycle(14'h00c, 0);
        readCycle(14'h006, 0);
        readCycle(14'h000, 1);
        readCycle(14'h000, 1);

        $display("[TB] ertn return");
        applyStimulus(0, 0, 0, 0, 0, 1, 14'h000, 0, 0, 0, 1);
        readCycle(14'h000, 1);
        readCycle(14'h000, 1);
        readCycle(14'h000, 1);

        $display("[TB] masked writes");
        writeCycle(14'h005, 32'hffff_ffff, 32'hffff_ffff);
        readCycle(14'h005, 1);
        writeCycle(14'h007, 32'hffff_ffff, 32'hdead_beef);
        readCycle(14'h007, 1);

        $display("[TB] simultaneous events and busy drops");
        writeCycle(14'h030, 32'hffff_ffff, 32'h1234_5678);
        applyStimulus(0, 1, 6'h3, 9'h1a5, 32'h1c00_0200, 1, 14'h030, 1, 32'hffff_ffff, 32'h0bad_0bad, 0);
        applyStimulus(0, 1, 6'h4, 9'h0, 32'h1c00_0300, 0, 14'h006, 1, 32'hffff_ffff, 32'h0, 0);
        applyStimulus(0, 1, 6'h4, 9'h0, 32'h1c00_0400, 1, 14'h006, 0, 0, 0, 0);
        readCycle(14'h030, 1);
        readCycle(14'h006, 1);

        $display("[TB] reset during sequence");
        applyStimulus(0, 1, 6'h1, 9'h0, 32'h1c00_0500, 0, 14'h006, 0, 0, 0, 0);
        readCycle(14'h006, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 14'h006, 0, 0, 0, 0);
        readCycle(14'h000, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            n = nums[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) n = 14'($urandom);
            applyStimulus(
                $urandom_range(0, 199) == 0,
                $urandom_range(0, 7) == 0,
                6'($urandom), 9'($urandom), $urandom,
                $urandom_range(0, 7) == 0,
                n,
                $urandom_range(0, 1) == 1,
                ($urandom_range(0, 1) == 1) ? 32'hffff_ffff : $urandom,
                $urandom,
                $urandom_range(0, 1) == 1);
        end

        checkOutput("redirect queue drained", 32'(redir_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
